host_axil_regs: RTL and testbench
=================================

Name: host_axil_regs

Overview:
AXI-Lite slave register file between the host bus and the GPU core, replacing the always-ready host stub. It implements full independent AW/W/B and AR/R handshakes with byte strobes. It exposes a scratch register and a control register to the core, and returns read-only status and ID words.

Parameters:
ID_VALUE, 32'h4650_0001, constant returned at offset 0x0C.
CTRL_RESET, 32'h0000_0001, reset value of CTRL (video enabled).

Ports:
clk  in  1  core clock; all logic on rising edge
rst  in  1  synchronous active-high reset
host_awaddr  in  32  write address
host_awvalid  in  1  write address valid
host_awready  out  1  write address ready
host_wdata  in  32  write data
host_wstrb  in  4  byte-lane enables; bit i covers wdata[8i+7:8i]
host_wvalid  in  1  write data valid
host_wready  out  1  write data ready
host_bresp  out  2  write response: 00 OKAY, 10 SLVERR
host_bvalid  out  1  write response valid
host_bready  in  1  write response accept
host_araddr  in  32  read address
host_arvalid  in  1  read address valid
host_arready  out  1  read address ready
host_rdata  out  32  read data
host_rresp  out  2  read response
host_rvalid  out  1  read data valid
host_rready  in  1  read data accept
status_i  in  32  live status word (frame counter etc.), sampled on read
scratch_o  out  32  SCRATCH register contents
ctrl_o  out  32  CTRL register contents (bit0 video_en, bit1 pattern_sel)

Behaviour:
- Reset (rst high at an edge): scratch_o=0; ctrl_o=CTRL_RESET; bvalid=0, rvalid=0; bresp=00, rresp=00, rdata=0; AW/W holding buffers empty, so awready=wready=arready=1 the following cycle. Reset mid-transaction drops all in-flight state; no partial write is committed.
- Register map uses addr[3:2]; addr[31:4] must be zero, otherwise the access is unmapped. 0x00 SCRATCH (RW), 0x04 CTRL (RW), 0x08 STATUS (RO = status_i), 0x0C ID (RO = ID_VALUE). addr[1:0] is ignored.
- AW buffer: awready = AW buffer empty (registered flag). A handshake at an edge captures awaddr. The W buffer works the same way with wready, capturing wdata and wstrb. AW and W are accepted independently, in either order or in the same cycle.
- Write commit: at an edge where both buffers are full and bvalid=0:
  - For RW targets, each byte lane with wstrb=1 is updated; other lanes are unchanged.
  - Both buffers clear and bvalid is set.
  - bresp is 00 for an RW target, 10 for RO or unmapped targets; RO and unmapped writes change nothing.
- Latency: a same-edge AW+W handshake at edge E0 commits at E1. The new value is on scratch_o/ctrl_o and bvalid=1 after E1.
- bvalid and bresp hold until the edge with bready=1, then bvalid clears. A new AW/W may be buffered while bvalid=1, but it does not commit until bvalid has cleared; at most one write is outstanding.
- Read: arready = !rvalid. An AR handshake at edge E0 loads rdata/rresp and sets rvalid at E0, so data is visible after E0, 1-cycle latency.
  - Unmapped reads return rdata=0, rresp=10. Mapped reads return rresp=00.
  - STATUS returns the status_i value present at the handshake edge.
- rvalid, rdata and rresp hold stable until an edge with rready=1. arready is low while rvalid=1, so there is no read pipelining.
- Read and write paths are independent. Reading a register in the same edge as a write commit to it returns the pre-commit value.
- All outputs are registered or derived from registered flags only; there is no combinational path from any valid/ready input to any output.

Test Plan:
- Reset, then idle -> scratch_o=0, ctrl_o=1, awready=wready=arready=1, bvalid=rvalid=0.
- AW(0x00)+W(0xDEADBEEF, strb=F) same cycle, bready=1 -> scratch_o=DEADBEEF and bvalid=1 exactly 1 edge after handshake, bresp=00, bvalid clears next edge.
- W(0x000000AA, strb=1) 3 cycles before AW(0x00), with scratch=DEADBEEF -> wready low after W captured; scratch_o=DEADBEAA after commit.
- Write 0x08 and write 0x40 -> bresp=10 for each, scratch_o/ctrl_o unchanged. Read 0x40 -> rdata=0, rresp=10. Read 0x0C -> 4650_0001, rresp=00.
- Read 0x08 with status_i=0x1234 and rready held low for 5 cycles, status_i changing -> rdata stays 0x1234, arready=0 throughout, single beat on release.
- bready held low after write 1, second AW/W presented -> both buffered, no second commit until bvalid handshake; then second commit and second bvalid. Assert rst mid-sequence -> all valids low next cycle, registers at reset values.

Source files
------------

// File: rtl/host_axil_regs_if.sv
// AXI-Lite host bus bundle for the GPU register file.
// The master modport is the host side; the slave modport is the register file.
interface host_axil_regs_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/host_axil_regs.sv
// AXI-Lite slave register file between the host bus and the GPU core.
// Map (addr[3:2], addr[31:4] must be zero):
//   0x00 SCRATCH (RW), 0x04 CTRL (RW), 0x08 STATUS (RO), 0x0C ID (RO).
// AW and W are each held in a one-entry buffer; a write commits once both
// are present and no response is outstanding. Reads answer one cycle after
// the AR handshake and hold until accepted.
module host_axil_regs #(
    parameter logic [31:0] ID_VALUE   = 32'h4650_0001,
    parameter logic [31:0] CTRL_RESET = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              rst,
    host_axil_regs_if.slave   host,
    input  logic [31:0]       status_i,
    output logic [31:0]       scratch_o,
    output logic [31:0]       ctrl_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-side holding buffers
    logic        aw_full;
    logic [31:0] aw_addr;
    logic        w_full;
    logic [31:0] w_data;
    logic [3:0]  w_strb;

    // Response and read-data registers
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic [31:0] scratch_q;
    logic [31:0] ctrl_q;

    // Handshakes use only registered ready flags, so no valid->ready path exists.
    logic aw_hs, w_hs, ar_hs, commit;
    assign aw_hs  = host.awvalid && !aw_full;
    assign w_hs   = host.wvalid  && !w_full;
    assign ar_hs  = host.arvalid && !rvalid_q;
    assign commit = aw_full && w_full && !bvalid_q;

    // Write target decode from the buffered address.
    logic wr_mapped, wr_rw;
    assign wr_mapped = (aw_addr[31:4] == 28'd0);
    assign wr_rw     = wr_mapped && !aw_addr[3];

    // Byte-lane addr bits are ignored by the register map.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{aw_addr[1:0], host.araddr[1:0]};

    // Merge new data into an existing word under the byte strobes.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) result[8*i +: 8] = new_word[8*i +: 8];
        end
        return result;
    endfunction

    // AW buffer: fill on handshake, drain on commit.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking here would let later blocks see half-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full <= 1'b0;
        end else if (commit) begin
            aw_full <= 1'b0;
        end else if (aw_hs) begin
            aw_full <= 1'b1;
        end
    end

    // Buffered address/data payloads, qualified by the full flags.
    // NOTE: payload registers are not reset; the full flags gate every use,
    // so only the flags need a known value.
    always_ff @(posedge clk) begin
        if (aw_hs) aw_addr <= host.awaddr;
        if (w_hs) begin
            w_data <= host.wdata;
            w_strb <= host.wstrb;
        end
    end

    // W buffer: fill on handshake, drain on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_full <= 1'b0;
        end else if (commit) begin
            w_full <= 1'b0;
        end else if (w_hs) begin
            w_full <= 1'b1;
        end
    end

    // RW registers: byte-masked update on a commit to SCRATCH or CTRL.
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch_q <= 32'd0;
            ctrl_q    <= CTRL_RESET;
        end else if (commit && wr_rw) begin
            if (!aw_addr[2]) scratch_q <= merge_bytes(scratch_q, w_data, w_strb);
            else             ctrl_q    <= merge_bytes(ctrl_q,    w_data, w_strb);
        end
    end

    // Write response: raised by a commit, held until bready.
    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_rw ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && host.bready) begin
            bvalid_q <= 1'b0;
        end
    end

    // Read mux for the address currently on araddr.
    logic [31:0] rd_word;
    logic [1:0]  rd_resp;
    // NOTE: defaults first so every path assigns both outputs and no latch forms.
    always_comb begin
        rd_word = 32'd0;
        rd_resp = RESP_SLVERR;
        if (host.araddr[31:4] == 28'd0) begin
            rd_resp = RESP_OKAY;
            case (host.araddr[3:2])
                2'd0:    rd_word = scratch_q;
                2'd1:    rd_word = ctrl_q;
                2'd2:    rd_word = status_i;
                default: rd_word = ID_VALUE;
            endcase
        end
    end

    // Read channel: load on AR handshake, hold until rready.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            rresp_q  <= rd_resp;
        end else if (rvalid_q && host.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign host.awready = !aw_full;
    assign host.wready  = !w_full;
    assign host.bvalid  = bvalid_q;
    assign host.bresp   = bresp_q;
    assign host.arready = !rvalid_q;
    assign host.rvalid  = rvalid_q;
    assign host.rdata   = rdata_q;
    assign host.rresp   = rresp_q;
    assign scratch_o    = scratch_q;
    assign ctrl_o       = ctrl_q;

endmodule

// File: tb/tb_host_axil_regs.sv
// Self-checking bench for host_axil_regs: directed handshake scenarios
// followed by random reads/writes compared against a register-map model.
module tb_host_axil_regs;

    localparam logic [31:0] ID_VAL   = 32'h4650_0001;
    localparam logic [31:0] CTRL_RST = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] status_i = 32'd0;
    logic [31:0] scratch_o;
    logic [31:0] ctrl_o;

    host_axil_regs_if bus();

    host_axil_regs #(.ID_VALUE(ID_VAL), .CTRL_RESET(CTRL_RST)) dut (
        .clk       (clk),
        .rst       (rst),
        .host      (bus),
        .status_i  (status_i),
        .scratch_o (scratch_o),
        .ctrl_o    (ctrl_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: index 0 = SCRATCH, 1 = CTRL.
    logic [31:0] m_reg [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_reg[0] = 32'd0;
        m_reg[1] = CTRL_RST;
    endfunction

    // Read as the register map defines it.
    function automatic logic [31:0] model_read(input logic [31:0] a, output logic [1:0] resp);
        int idx;
        if (a >= 32'h10) begin
            resp = 2'b10;
            return 32'd0;
        end
        resp = 2'b00;
        idx = int'(a) / 4;
        if (idx == 0) return m_reg[0];
        if (idx == 1) return m_reg[1];
        if (idx == 2) return status_i;
        return ID_VAL;
    endfunction

    // Apply a write to the model; returns the expected response.
    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        int idx;
        if (a >= 32'h10) return 2'b10;
        idx = int'(a) / 4;
        if (idx >= 2) return 2'b10;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) m_reg[idx][8*i +: 8] = d[8*i +: 8];
        end
        return 2'b00;
    endfunction

    task automatic idle_bus();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        bus.bready  = 1'b0; bus.rready = 1'b0;
    endtask

    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        for (int i = 0; i < 50 && !(bus.awready && bus.wready); i++) tick();
        check("aw_w_ready", {30'd0, bus.awready, bus.wready}, 32'd3);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] a);
        bus.awaddr = a; bus.awvalid = 1'b1;
        for (int i = 0; i < 50 && !bus.awready; i++) tick();
        check("aw_ready", {31'd0, bus.awready}, 32'd1);
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        for (int i = 0; i < 50 && !bus.wready; i++) tick();
        check("w_ready", {31'd0, bus.wready}, 32'd1);
        tick();
        bus.wvalid = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp);
        bus.bready = 1'b1;
        for (int i = 0; i < 50 && !bus.bvalid; i++) tick();
        check("b_timeout", {31'd0, bus.bvalid}, 32'd1);
        resp = bus.bresp;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
        bus.araddr = a; bus.arvalid = 1'b1;
        for (int i = 0; i < 50 && !bus.arready; i++) tick();
        check("ar_ready", {31'd0, bus.arready}, 32'd1);
        tick();
        bus.arvalid = 1'b0;
        check("r_latency", {31'd0, bus.rvalid}, 32'd1);
        data = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("r_release", {31'd0, bus.rvalid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp, eresp;
        logic [31:0] data, edata, a, d;
        logic [3:0]  s;

        idle_bus();
        bus.awaddr = 32'd0; bus.wdata = 32'd0; bus.wstrb = 4'd0; bus.araddr = 32'd0;
        model_reset();

        // Reset and idle
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_scratch", scratch_o, 32'd0);
        check("rst_ctrl", ctrl_o, CTRL_RST);
        check("rst_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);
        check("rst_valids", {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);

        // Same-cycle AW+W: commit exactly one edge after handshake
        bus.awaddr = 32'h0; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("e0_bvalid", {31'd0, bus.bvalid}, 32'd0);
        check("e0_awready", {31'd0, bus.awready}, 32'd0);
        check("e0_scratch", scratch_o, 32'd0);
        tick();
        eresp = model_write(32'h0, 32'hDEAD_BEEF, 4'hF);
        check("e1_bvalid", {31'd0, bus.bvalid}, 32'd1);
        check("e1_bresp", {30'd0, bus.bresp}, {30'd0, eresp});
        check("e1_scratch", scratch_o, 32'hDEAD_BEEF);
        tick();
        bus.bready = 1'b0;
        check("e2_bvalid", {31'd0, bus.bvalid}, 32'd0);

        // W three cycles ahead of AW, single-byte strobe
        send_w(32'h0000_00AA, 4'h1);
        check("w_held_0", {31'd0, bus.wready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("w_held", {31'd0, bus.wready}, 32'd0);
        end
        check("w_only_no_b", {31'd0, bus.bvalid}, 32'd0);
        send_aw(32'h0);
        get_b(resp);
        eresp = model_write(32'h0, 32'h0000_00AA, 4'h1);
        check("wfirst_bresp", {30'd0, resp}, {30'd0, eresp});
        check("wfirst_scratch", scratch_o, 32'hDEAD_BEAA);

        // Writes to RO and unmapped targets
        send_aw_w(32'h08, 32'hFFFF_FFFF, 4'hF);
        get_b(resp);
        check("ro_bresp", {30'd0, resp}, 32'd2);
        send_aw_w(32'h40, 32'hFFFF_FFFF, 4'hF);
        get_b(resp);
        check("unmap_bresp", {30'd0, resp}, 32'd2);
        check("ro_scratch", scratch_o, 32'hDEAD_BEAA);
        check("ro_ctrl", ctrl_o, CTRL_RST);
        do_read(32'h40, data, resp);
        check("unmap_rdata", data, 32'd0);
        check("unmap_rresp", {30'd0, resp}, 32'd2);
        do_read(32'h0C, data, resp);
        check("id_rdata", data, 32'h4650_0001);
        check("id_rresp", {30'd0, resp}, 32'd0);

        // STATUS sampled at the handshake, held while rready is low
        status_i = 32'h1234;
        bus.araddr = 32'h08; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check("st_rvalid", {31'd0, bus.rvalid}, 32'd1);
        check("st_rdata", bus.rdata, 32'h1234);
        for (int i = 0; i < 5; i++) begin
            status_i = $urandom;
            tick();
            check("st_hold_rdata", bus.rdata, 32'h1234);
            check("st_hold_arready", {31'd0, bus.arready}, 32'd0);
            check("st_hold_rvalid", {31'd0, bus.rvalid}, 32'd1);
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("st_single_beat", {31'd0, bus.rvalid}, 32'd0);
        check("st_arready", {31'd0, bus.arready}, 32'd1);

        // Read on the same edge as a commit sees the pre-commit value
        bus.awaddr = 32'h0; bus.wdata = 32'h5566_7788; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 32'h0; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check("rw_race_rdata", bus.rdata, m_reg[0]);
        eresp = model_write(32'h0, 32'h5566_7788, 4'hF);
        check("rw_race_scratch", scratch_o, 32'h5566_7788);
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;

        // Second write buffered behind an unaccepted response
        send_aw_w(32'h0, 32'h1111_1111, 4'hF);
        tick();
        check("ov_b1", {31'd0, bus.bvalid}, 32'd1);
        eresp = model_write(32'h0, 32'h1111_1111, 4'hF);
        send_aw_w(32'h4, 32'h0000_0002, 4'hF);
        for (int i = 0; i < 3; i++) tick();
        check("ov_ctrl_old", ctrl_o, m_reg[1]);
        check("ov_buffered", {30'd0, bus.awready, bus.wready}, 32'd0);
        check("ov_b_hold", {31'd0, bus.bvalid}, 32'd1);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("ov_b_clear", {31'd0, bus.bvalid}, 32'd0);
        check("ov_ctrl_still_old", ctrl_o, m_reg[1]);
        tick();
        eresp = model_write(32'h4, 32'h0000_0002, 4'hF);
        check("ov_b2", {31'd0, bus.bvalid}, 32'd1);
        check("ov_ctrl_new", ctrl_o, 32'h0000_0002);
        get_b(resp);
        check("ov_bresp2", {30'd0, resp}, {30'd0, eresp});

        // Random traffic against the model
        for (int n = 0; n < 60; n++) begin
            int sel;
            sel = $urandom_range(0, 4);
            if (sel < 4) a = 32'(sel * 4 + $urandom_range(0, 3));
            else begin
                a = $urandom;
                if (a < 32'h10) a = a | 32'h10;
            end
            status_i = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                case ($urandom_range(0, 2))
                    0: send_aw_w(a, d, s);
                    1: begin send_w(d, s); send_aw(a); end
                    default: begin send_aw(a); send_w(d, s); end
                endcase
                get_b(resp);
                eresp = model_write(a, d, s);
                check("rnd_bresp", {30'd0, resp}, {30'd0, eresp});
                check("rnd_scratch", scratch_o, m_reg[0]);
                check("rnd_ctrl", ctrl_o, m_reg[1]);
            end else begin
                edata = model_read(a, eresp);
                do_read(a, data, resp);
                check("rnd_rdata", data, edata);
                check("rnd_rresp", {30'd0, resp}, {30'd0, eresp});
            end
        end

        // Reset in the middle of a buffered write and a pending read
        bus.awaddr = 32'h0; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 32'h0C; bus.arvalid = 1'b1;
        tick();
        idle_bus();
        check("mid_rvalid_pre", {31'd0, bus.rvalid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("mid_valids", {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
        check("mid_scratch", scratch_o, m_reg[0]);
        check("mid_ctrl", ctrl_o, m_reg[1]);
        check("mid_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);
        tick(); tick();
        check("mid_no_commit_b", {31'd0, bus.bvalid}, 32'd0);
        check("mid_no_commit_scratch", scratch_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
